// File: rtl/hitlc_sel_pipe.sv
// hitlc_sel_pipe: N-channel hitmap/lcmap selector with auto-scan
// sequencer and a fixed-latency aligned delay line toward the fit stage.
module hitlc_sel_pipe #(
    parameter int NCH   = 6,
    parameter int NL    = 5,
    parameter int DEPTH = 2,
    parameter int SELW  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sel_mode,
    input  logic [SELW-1:0]   sel_chi,
    input  logic              scan_start,
    input  logic              in_valid,
    input  logic [NCH*NL-1:0] hitmap_in,
    input  logic [NCH*NL-1:0] lcmap_in,
    input  logic              err_clr,
    output logic [NL-1:0]     hitmap_current,
    output logic [NL-1:0]     hitmap,
    output logic [NL-1:0]     lcmap,
    output logic              out_valid,
    output logic [SELW-1:0]   out_chi,
    output logic              scan_busy,
    output logic              scan_done,
    output logic              sel_err
);

    localparam logic [SELW:0]   NCH_X = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] LAST  = SELW'(NCH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    typedef struct packed {
        logic            v;
        logic [SELW-1:0] chi;
        logic [NL-1:0]   hit;
        logic [NL-1:0]   lc;
    } stage_t;

    state_t          state_q;
    state_t          state_d;
    logic [SELW-1:0] cnt_q;
    logic [SELW-1:0] cnt_d;
    logic            done_q;
    logic            done_d;
    logic            err_q;

    logic [SELW-1:0] eff;
    logic            bad;
    logic [SELW-1:0] sel;
    logic [NL-1:0]   hit_sel;
    logic [NL-1:0]   lc_sel;

    stage_t          pipe_q [DEPTH];
    stage_t          tail;

    // Effective index; out-of-range falls back to channel 0
    always_comb begin
        eff = sel_mode ? cnt_q : sel_chi;
        bad = ({1'b0, eff} >= NCH_X);
        sel = bad ? '0 : eff;
    end

    // Channel mux for hitmap and lcmap
    always_comb begin
        hit_sel = hitmap_in[NL-1:0];
        lc_sel  = lcmap_in[NL-1:0];
        for (int k = 1; k < NCH; k++) begin
            if (sel == SELW'(k)) begin
                hit_sel = hitmap_in[k*NL +: NL];
                lc_sel  = lcmap_in[k*NL +: NL];
            end
        end
    end

    // Scan sequencer next-state and done pulse
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_mode && scan_start) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (!sel_mode) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (in_valid) begin
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Scan sequencer state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Sticky selection error; a new error beats a clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (in_valid && bad) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    // Free-running aligned delay line, no stall
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= '{v: in_valid, chi: sel,
                           hit: hit_sel, lc: lc_sel};
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Output taps, data zeroed when not valid
    always_comb begin
        tail           = pipe_q[DEPTH-1];
        hitmap_current = hit_sel;
        out_valid      = tail.v;
        hitmap         = tail.v ? tail.hit : '0;
        lcmap          = tail.v ? tail.lc  : '0;
        out_chi        = tail.v ? tail.chi : '0;
        scan_busy      = (state_q == SCAN);
        scan_done      = done_q;
        sel_err        = err_q;
    end

endmodule

// File: tb/tb_hitlc_sel_pipe.sv
// tb_hitlc_sel_pipe: directed stimulus with a queue-based
// reference model checked every cycle plus literal spot checks.
module tb_hitlc_sel_pipe;

    localparam int NCH   = 6;
    localparam int NL    = 5;
    localparam int DEPTH = 2;
    localparam int SELW  = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              sel_mode;
    logic [SELW-1:0]   sel_chi;
    logic              scan_start;
    logic              in_valid;
    logic [NCH*NL-1:0] hitmap_in;
    logic [NCH*NL-1:0] lcmap_in;
    logic              err_clr;
    logic [NL-1:0]     hitmap_current;
    logic [NL-1:0]     hitmap;
    logic [NL-1:0]     lcmap;
    logic              out_valid;
    logic [SELW-1:0]   out_chi;
    logic              scan_busy;
    logic              scan_done;
    logic              sel_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;
    bit rec_on = 0;
    int rec[$];

    hitlc_sel_pipe #(
        .NCH(NCH), .NL(NL), .DEPTH(DEPTH), .SELW(SELW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sel_mode(sel_mode),
        .sel_chi(sel_chi),
        .scan_start(scan_start),
        .in_valid(in_valid),
        .hitmap_in(hitmap_in),
        .lcmap_in(lcmap_in),
        .err_clr(err_clr),
        .hitmap_current(hitmap_current),
        .hitmap(hitmap),
        .lcmap(lcmap),
        .out_valid(out_valid),
        .out_chi(out_chi),
        .scan_busy(scan_busy),
        .scan_done(scan_done),
        .sel_err(sel_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        int chi;
        int hit;
        int lc;
    } smp_t;

    smp_t q[$];
    smp_t m_out;
    bit   m_scan;
    int   m_cnt;
    bit   m_err;
    bit   m_done;

    function automatic int hmap(int ch);
        return int'(hitmap_in[ch*NL +: NL]);
    endfunction

    function automatic int lmap(int ch);
        return int'(lcmap_in[ch*NL +: NL]);
    endfunction

    function automatic int eff_ch();
        int e;
        e = sel_mode ? m_cnt : int'(sel_chi);
        return (e >= NCH) ? 0 : e;
    endfunction

    task automatic model_reset();
        smp_t z;
        z = '{v: 0, chi: 0, hit: 0, lc: 0};
        q.delete();
        for (int i = 0; i < DEPTH - 1; i++) q.push_back(z);
        m_out  = z;
        m_scan = 0;
        m_cnt  = 0;
        m_err  = 0;
        m_done = 0;
    endtask

    task automatic model_step();
        smp_t s;
        int   e;
        int   ch;
        e  = sel_mode ? m_cnt : int'(sel_chi);
        ch = (e >= NCH) ? 0 : e;
        s  = '{v: in_valid, chi: ch, hit: hmap(ch), lc: lmap(ch)};
        q.push_back(s);
        m_out  = q.pop_front();
        m_done = m_scan && sel_mode && in_valid && (m_cnt == NCH - 1);
        if (in_valid && e >= NCH) m_err = 1;
        else if (err_clr)         m_err = 0;
        if (m_scan) begin
            if (!sel_mode) begin
                m_scan = 0;
                m_cnt  = 0;
            end else if (in_valid) begin
                m_cnt++;
                if (m_cnt == NCH) begin
                    m_cnt  = 0;
                    m_scan = 0;
                end
            end
        end else if (sel_mode && scan_start) begin
            m_scan = 1;
            m_cnt  = 0;
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (chk_on) begin
            check("out_valid", 32'(out_valid), 32'(m_out.v));
            check("hitmap", 32'(hitmap), m_out.v ? m_out.hit : 0);
            check("lcmap", 32'(lcmap), m_out.v ? m_out.lc : 0);
            check("out_chi", 32'(out_chi), m_out.v ? m_out.chi : 0);
            check("scan_busy", 32'(scan_busy), 32'(m_scan));
            check("scan_done", 32'(scan_done), 32'(m_done));
            check("sel_err", 32'(sel_err), 32'(m_err));
            check("hitmap_current", 32'(hitmap_current),
                  hmap(eff_ch()));
        end
        if (rec_on && out_valid === 1'b1) rec.push_back(int'(out_chi));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_maps(input int seed);
        for (int k = 0; k < NCH; k++) begin
            hitmap_in[k*NL +: NL] = NL'((seed * 5 + k * 7 + 3) % 32);
            lcmap_in[k*NL +: NL]  = NL'((seed * 11 + k * 13 + 1) % 32);
        end
    endtask

    task automatic check_rec(input string name, input int first);
        check({name, "_count"}, rec.size(), NCH);
        for (int i = 0; i < rec.size(); i++) begin
            check(name, rec[i], first + i);
        end
        rec.delete();
    endtask

    initial begin
        reset      = 1'b1;
        sel_mode   = 1'b0;
        sel_chi    = '0;
        scan_start = 1'b0;
        in_valid   = 1'b0;
        err_clr    = 1'b0;
        hitmap_in  = '0;
        lcmap_in   = '0;
        repeat (2) tick();
        chk_on = 1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sel_err", 32'(sel_err), 0);
        reset = 1'b0;
        tick();

        // 1: single external selection
        set_maps(1);
        hitmap_in[3*NL +: NL] = 5'h15;
        lcmap_in[3*NL +: NL]  = 5'h0A;
        sel_chi  = 3'd3;
        in_valid = 1'b1;
        #1;
        check("t1_current", 32'(hitmap_current), 32'h15);
        tick();
        in_valid = 1'b0;
        check("t1_lat1_valid", 32'(out_valid), 0);
        tick();
        check("t1_valid", 32'(out_valid), 1);
        check("t1_hitmap", 32'(hitmap), 32'h15);
        check("t1_lcmap", 32'(lcmap), 32'h0A);
        check("t1_chi", 32'(out_chi), 3);
        tick();
        check("t1_after", 32'(out_valid), 0);

        // 2: back-to-back external indices 0..5
        rec_on = 1;
        for (int i = 0; i < NCH; i++) begin
            set_maps(i + 10);
            sel_chi  = SELW'(i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        rec_on = 0;
        check_rec("t2_chi", 0);

        // 3: auto-scan with a gap
        sel_mode   = 1'b1;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        check("t3_busy", 32'(scan_busy), 1);
        rec_on = 1;
        for (int i = 0; i < NCH; i++) begin
            set_maps(i + 20);
            in_valid = 1'b1;
            if (i == 1) scan_start = 1'b1;
            tick();
            scan_start = 1'b0;
            if (i == 2) begin
                in_valid = 1'b0;
                repeat (2) tick();
            end
        end
        in_valid = 1'b0;
        check("t3_done", 32'(scan_done), 1);
        check("t3_busy_end", 32'(scan_busy), 0);
        tick();
        check("t3_done_pulse", 32'(scan_done), 0);
        repeat (2) tick();
        rec_on = 0;
        check_rec("t3_chi", 0);

        // 4: out-of-range index and sticky error
        sel_mode = 1'b0;
        set_maps(40);
        hitmap_in[NL-1:0] = 5'h11;
        sel_chi  = 3'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        sel_chi  = 3'd0;
        check("t4_err_set", 32'(sel_err), 1);
        tick();
        check("t4_valid", 32'(out_valid), 1);
        check("t4_chi", 32'(out_chi), 0);
        check("t4_hit", 32'(hitmap), 32'h11);
        repeat (2) tick();
        check("t4_sticky", 32'(sel_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_clear", 32'(sel_err), 0);
        sel_chi  = 3'd6;
        in_valid = 1'b1;
        tick();
        check("t4_err6", 32'(sel_err), 1);
        sel_chi = 3'd7;
        err_clr = 1'b1;
        tick();
        check("t4_set_wins", 32'(sel_err), 1);
        in_valid = 1'b0;
        tick();
        err_clr = 1'b0;
        check("t4_clear2", 32'(sel_err), 0);
        repeat (2) tick();

        // 5: async reset with samples in flight
        sel_chi  = 3'd2;
        in_valid = 1'b1;
        tick();
        sel_chi = 3'd4;
        tick();
        in_valid = 1'b0;
        check("t5_inflight", 32'(out_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_valid", 32'(out_valid), 0);
        check("t5_rst_hit", 32'(hitmap), 0);
        check("t5_rst_lc", 32'(lcmap), 0);
        check("t5_rst_chi", 32'(out_chi), 0);
        tick();
        reset = 1'b0;
        tick();
        check("t5_drained", 32'(out_valid), 0);
        sel_chi  = 3'd1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t5_lat1", 32'(out_valid), 0);
        tick();
        check("t5_lat2", 32'(out_valid), 1);
        check("t5_chi", 32'(out_chi), 1);
        tick();

        // 6: abort mid-scan, then restart with start+valid together
        sel_mode   = 1'b1;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_maps(i + 50);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        sel_mode = 1'b0;
        tick();
        check("t6_abort_busy", 32'(scan_busy), 0);
        check("t6_abort_done", 32'(scan_done), 0);
        tick();
        check("t6_no_done", 32'(scan_done), 0);
        sel_mode   = 1'b1;
        scan_start = 1'b1;
        in_valid   = 1'b1;
        tick();
        scan_start = 1'b0;
        check("t6_restart_busy", 32'(scan_busy), 1);
        tick();
        in_valid = 1'b0;
        check("t6_first_valid", 32'(out_valid), 1);
        check("t6_first_chi", 32'(out_chi), 0);
        tick();
        check("t6_second_chi", 32'(out_chi), 0);
        tick();
        sel_mode = 1'b0;
        repeat (3) tick();

        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
